// File: rtl/conv_feeder_pkg.sv
// conv_feeder shared definitions: state encoding,
// cfg word field offsets and default data width.
package conv_feeder_pkg;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int CFG_W          = 64;

    localparam int WCFG_LSB = 0;
    localparam int WCFG_MSB = 31;
    localparam int FCFG_LSB = 32;
    localparam int FCFG_MSB = 63;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_CFG  = 3'd1;
    localparam state_t ST_ARB  = 3'd2;
    localparam state_t ST_WEI  = 3'd3;
    localparam state_t ST_FTM  = 3'd4;
    localparam state_t ST_DONE = 3'd5;

endpackage

// File: rtl/conv_feeder_burst.sv
// One stream's unit word counter plus the
// source-to-di/we register stage (latency 1).
module conv_feeder_burst
    import conv_feeder_pkg::*;
#(
    parameter int DW   = DATA_WIDTH_DEF,
    parameter int UNIT = 32,
    parameter int CW   = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] src_data,
    input  logic          src_valid,
    output logic          src_ready,
    output logic          last,
    output logic          we,
    output logic [DW-1:0] di
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [DW-1:0] di_q, di_d;
    logic          acc;

    assign src_ready = en;
    assign acc       = en & src_valid;
    assign last      = acc && (cnt_q == CW'(UNIT - 1));
    assign we        = we_q;
    assign di        = di_q;

    // Capture accepted words; counter wraps at the unit end.
    always_comb begin
        cnt_d = cnt_q;
        di_d  = di_q;
        we_d  = acc;
        if (acc) begin
            di_d  = src_data;
            cnt_d = last ? '0 : cnt_q + CW'(1);
        end
    end

    // Counter and output stage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            we_q  <= 1'b0;
            di_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            we_q  <= we_d;
            di_q  <= di_d;
        end
    end

endmodule

// File: rtl/conv_feeder.sv
// Conv-unit load transmitter: cfg handshake, then
// unit bursts of weight / feature data onto di.
module conv_feeder
    import conv_feeder_pkg::*;
#(
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int UNIT_BURSTS_WEI = 32,
    parameter int UNIT_BURSTS_FTM = 1024,
    parameter int B_UNITS         = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CFG_W-1:0]      cmd_cfg,
    input  logic [B_UNITS-1:0]    cmd_n_wei,
    input  logic [B_UNITS-1:0]    cmd_n_ftm,
    input  logic                  cmd_clr,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] wei_data,
    input  logic                  wei_valid,
    output logic                  wei_ready,
    input  logic [DATA_WIDTH-1:0] ftm_data,
    input  logic                  ftm_valid,
    output logic                  ftm_ready,
    output logic [CFG_W-1:0]      cfg_o_data,
    output logic [1:0]            cfg_o_valid,
    input  logic [1:0]            cfg_o_ready,
    output logic                  wb_we,
    output logic                  fb_we,
    output logic                  wb_clr,
    output logic                  fb_clr,
    output logic [DATA_WIDTH-1:0] di,
    input  logic                  wb_full,
    input  logic                  fb_full,
    output logic                  done
);

    localparam int CNT_W = $clog2(UNIT_BURSTS_FTM);

    state_t               state_q, state_d;
    logic [CFG_W-1:0]     cfg_q, cfg_d;
    logic [B_UNITS-1:0]   wrem_q, wrem_d;
    logic [B_UNITS-1:0]   frem_q, frem_d;
    logic [1:0]           sent_q, sent_d;
    logic                 clr_q, clr_d;
    logic                 sel_q, sel_d;

    logic                  wei_en, ftm_en;
    logic                  wei_last, ftm_last;
    logic [DATA_WIDTH-1:0] wei_di, ftm_di;
    logic [1:0]            cfg_hs;
    logic                  accept;

    assign accept = (state_q == ST_IDLE) & cmd_valid;
    assign cfg_hs = cfg_o_valid & cfg_o_ready;

    conv_feeder_burst #(
        .DW   (DATA_WIDTH),
        .UNIT (UNIT_BURSTS_WEI),
        .CW   (CNT_W)
    ) u_wei (
        .clk       (clk),
        .rst       (rst),
        .en        (wei_en),
        .src_data  (wei_data),
        .src_valid (wei_valid),
        .src_ready (wei_ready),
        .last      (wei_last),
        .we        (wb_we),
        .di        (wei_di)
    );

    conv_feeder_burst #(
        .DW   (DATA_WIDTH),
        .UNIT (UNIT_BURSTS_FTM),
        .CW   (CNT_W)
    ) u_ftm (
        .clk       (clk),
        .rst       (rst),
        .en        (ftm_en),
        .src_data  (ftm_data),
        .src_valid (ftm_valid),
        .src_ready (ftm_ready),
        .last      (ftm_last),
        .we        (fb_we),
        .di        (ftm_di)
    );

    // State and command context registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cfg_q   <= '0;
            wrem_q  <= '0;
            frem_q  <= '0;
            sent_q  <= '0;
            clr_q   <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            wrem_q  <= wrem_d;
            frem_q  <= frem_d;
            sent_q  <= sent_d;
            clr_q   <= clr_d;
            sel_q   <= sel_d;
        end
    end

    // Next state: weight units win arbitration at each boundary.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (cmd_valid) state_d = ST_CFG;
            ST_CFG:  if (&(sent_q | cfg_hs)) state_d = ST_ARB;
            ST_ARB: begin
                if (wrem_q != '0 && !wb_full)      state_d = ST_WEI;
                else if (frem_q != '0 && !fb_full) state_d = ST_FTM;
                else if (wrem_q == '0 && frem_q == '0)
                    state_d = ST_DONE;
            end
            ST_WEI:  if (wei_last) state_d = ST_ARB;
            ST_FTM:  if (ftm_last) state_d = ST_ARB;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Command latch, cfg progress, unit remainders, di source.
    always_comb begin
        cfg_d  = cfg_q;
        wrem_d = wrem_q;
        frem_d = frem_q;
        sent_d = sent_q;
        clr_d  = accept & cmd_clr;
        sel_d  = wb_we ? 1'b0 : (fb_we ? 1'b1 : sel_q);
        if (accept) begin
            cfg_d  = {cmd_cfg[FCFG_MSB:FCFG_LSB],
                      cmd_cfg[WCFG_MSB:WCFG_LSB]};
            wrem_d = cmd_n_wei;
            frem_d = cmd_n_ftm;
            sent_d = '0;
        end
        if (state_q == ST_CFG) sent_d = sent_q | cfg_hs;
        if (wei_last && wrem_q != '0) wrem_d = wrem_q - 1'b1;
        if (ftm_last && frem_q != '0) frem_d = frem_q - 1'b1;
    end

    // Outputs decoded from state; di follows the last stream written.
    always_comb begin
        cmd_ready   = (state_q == ST_IDLE);
        cfg_o_valid = (state_q == ST_CFG) ? ~sent_q : 2'b00;
        done        = (state_q == ST_DONE);
        wei_en      = (state_q == ST_WEI);
        ftm_en      = (state_q == ST_FTM);
        cfg_o_data  = cfg_q;
        wb_clr      = clr_q;
        fb_clr      = clr_q;
        di          = (fb_we | (~wb_we & sel_q)) ? ftm_di : wei_di;
    end

endmodule

// File: tb/tb_conv_feeder.sv
// Directed bench for conv_feeder: cfg handshake table,
// bursts, back-pressure, bubbles, clear and async reset.
module tb_conv_feeder;

    localparam logic [63:0] CFGVAL = 64'hFCF0_0002_0C0F_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] cmd_cfg = '0;
    logic [15:0] cmd_n_wei = '0;
    logic [15:0] cmd_n_ftm = '0;
    logic        cmd_clr = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [63:0] wei_data = 64'h0000_0000_0000_1000;
    logic        wei_valid = 1'b0;
    logic        wei_ready;
    logic [63:0] ftm_data = 64'h0000_0000_0008_0000;
    logic        ftm_valid = 1'b0;
    logic        ftm_ready;
    logic [63:0] cfg_o_data;
    logic [1:0]  cfg_o_valid;
    logic [1:0]  cfg_o_ready = 2'b00;
    logic        wb_we, fb_we, wb_clr, fb_clr, done;
    logic [63:0] di;
    logic        wb_full = 1'b0;
    logic        fb_full = 1'b0;

    conv_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_cfg     (cmd_cfg),
        .cmd_n_wei   (cmd_n_wei),
        .cmd_n_ftm   (cmd_n_ftm),
        .cmd_clr     (cmd_clr),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .wei_data    (wei_data),
        .wei_valid   (wei_valid),
        .wei_ready   (wei_ready),
        .ftm_data    (ftm_data),
        .ftm_valid   (ftm_valid),
        .ftm_ready   (ftm_ready),
        .cfg_o_data  (cfg_o_data),
        .cfg_o_valid (cfg_o_valid),
        .cfg_o_ready (cfg_o_ready),
        .wb_we       (wb_we),
        .fb_we       (fb_we),
        .wb_clr      (wb_clr),
        .fb_clr      (fb_clr),
        .di          (di),
        .wb_full     (wb_full),
        .fb_full     (fb_full),
        .done        (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Source model: what each stream handed over at the last edge.
    logic        pend_w = 1'b0, pend_f = 1'b0;
    logic [63:0] pend_wd = '0, pend_fd = '0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_w = 1'b0;
            pend_f = 1'b0;
        end else begin
            pend_w  = wei_valid & wei_ready;
            pend_wd = wei_data;
            pend_f  = ftm_valid & ftm_ready;
            pend_fd = ftm_data;
        end
    end

    int wcnt = 0, fcnt = 0, cyc = 0, first_w = 0, last_w = 0;
    logic bubble = 1'b0;

    // Per-cycle write checks, counters and next source words.
    always @(negedge clk) begin
        cyc++;
        chk("wb_we_latency", {63'd0, wb_we}, {63'd0, pend_w});
        if (pend_w) chk("wb_di", di, pend_wd);
        chk("fb_we_latency", {63'd0, fb_we}, {63'd0, pend_f});
        if (pend_f) chk("fb_di", di, pend_fd);
        chk("we_exclusive", {63'd0, wb_we & fb_we}, 64'd0);
        if (wb_we) begin
            if (wcnt == 0) first_w = cyc;
            last_w = cyc;
            wcnt++;
        end
        if (fb_we) fcnt++;
        if (pend_w) wei_data = wei_data + 64'd1;
        if (pend_f) ftm_data = ftm_data + 64'd1;
        if (bubble) wei_valid = ~wei_valid;
    end

    task automatic wait_done(input int max, input string name);
        for (int i = 0; i < max; i++) begin
            if (done) break;
            step();
        end
        chk(name, {63'd0, done}, 64'd1);
    endtask

    task automatic send_cmd(input logic [15:0] nw, input logic [15:0] nf,
                            input logic clr);
        cmd_cfg   = CFGVAL;
        cmd_n_wei = nw;
        cmd_n_ftm = nf;
        cmd_clr   = clr;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) break;
            step();
        end
        chk("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
        step();
        cmd_valid = 1'b0;
        cmd_clr   = 1'b0;
    endtask

    typedef struct {
        logic        cv;
        logic [1:0]  rdy;
        logic        e_rdy;
        logic [1:0]  e_cv;
        logic        e_done;
        logic [63:0] e_cfgd;
    } vec_t;

    vec_t vt[8];

    initial begin
        int fc;
        vt[0] = '{1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 64'd0};
        vt[1] = '{1'b0, 2'b01, 1'b0, 2'b11, 1'b0, CFGVAL};
        vt[2] = '{1'b0, 2'b01, 1'b0, 2'b10, 1'b0, CFGVAL};
        vt[3] = '{1'b0, 2'b01, 1'b0, 2'b10, 1'b0, CFGVAL};
        vt[4] = '{1'b0, 2'b10, 1'b0, 2'b10, 1'b0, CFGVAL};
        vt[5] = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b0, CFGVAL};
        vt[6] = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b1, CFGVAL};
        vt[7] = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b0, CFGVAL};

        // Reset state
        step(); step();
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_cfg_valid", {62'd0, cfg_o_valid}, 64'd0);
        chk("rst_cfg_data", cfg_o_data, 64'd0);
        chk("rst_clr", {62'd0, wb_clr, fb_clr}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_di", di, 64'd0);
        chk("rst_ready", {62'd0, wei_ready, ftm_ready}, 64'd0);
        rst = 1'b0;

        // Cfg handshake table, zero unit counts
        cmd_cfg = CFGVAL;
        wcnt = 0;
        fcnt = 0;
        for (int i = 0; i < 8; i++) begin
            cmd_valid   = vt[i].cv;
            cfg_o_ready = vt[i].rdy;
            chk($sformatf("tbl%0d_cmd_ready", i), {63'd0, cmd_ready},
                {63'd0, vt[i].e_rdy});
            chk($sformatf("tbl%0d_cfg_valid", i), {62'd0, cfg_o_valid},
                {62'd0, vt[i].e_cv});
            chk($sformatf("tbl%0d_done", i), {63'd0, done},
                {63'd0, vt[i].e_done});
            chk($sformatf("tbl%0d_cfg_data", i), cfg_o_data, vt[i].e_cfgd);
            step();
        end
        chk("tbl_no_we", wcnt + fcnt, 64'd0);
        cfg_o_ready = 2'b11;

        // Two weight units, source always valid
        wei_valid = 1'b1;
        wcnt = 0;
        fcnt = 0;
        send_cmd(16'd2, 16'd0, 1'b0);
        wait_done(300, "wei2_done");
        step();
        chk("wei2_done_pulse", {63'd0, done}, 64'd0);
        chk("wei2_wcnt", wcnt, 64'd64);
        chk("wei2_fcnt", fcnt, 64'd0);

        // Back-pressure: feature unit goes first while wb_full
        wb_full = 1'b1;
        ftm_valid = 1'b1;
        wcnt = 0;
        fcnt = 0;
        send_cmd(16'd1, 16'd1, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            if (fcnt >= 1024) break;
            step();
        end
        chk("bp_fcnt", fcnt, 64'd1024);
        for (int i = 0; i < 6; i++) step();
        chk("bp_wcnt_held", wcnt, 64'd0);
        chk("bp_no_done", {63'd0, done}, 64'd0);
        wb_full = 1'b0;
        wait_done(100, "bp_done");
        chk("bp_wcnt", wcnt, 64'd32);
        chk("bp_fcnt_final", fcnt, 64'd1024);
        ftm_valid = 1'b0;

        // Source bubbles: valid toggles every cycle
        step();
        bubble = 1'b1;
        wcnt = 0;
        send_cmd(16'd1, 16'd0, 1'b0);
        wait_done(200, "bub_done");
        bubble = 1'b0;
        wei_valid = 1'b0;
        chk("bub_wcnt", wcnt, 64'd32);
        chk("bub_span", last_w - first_w + 1, 64'd63);

        // Buffer clear pulse
        step();
        chk("clr_before", {62'd0, wb_clr, fb_clr}, 64'd0);
        send_cmd(16'd0, 16'd0, 1'b1);
        chk("clr_pulse", {62'd0, wb_clr, fb_clr}, 64'd3);
        step();
        chk("clr_one_cycle", {62'd0, wb_clr, fb_clr}, 64'd0);
        wait_done(20, "clr_done");

        // Async reset in the middle of a feature unit
        ftm_valid = 1'b1;
        fcnt = 0;
        send_cmd(16'd0, 16'd1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            if (fcnt >= 100) break;
            step();
        end
        chk("mid_fb_we", {63'd0, fb_we}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_fb_we", {63'd0, fb_we}, 64'd0);
        chk("arst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("arst_ftm_ready", {63'd0, ftm_ready}, 64'd0);
        chk("arst_di", di, 64'd0);
        step(); step();
        rst = 1'b0;
        fc = fcnt;
        for (int i = 0; i < 10; i++) step();
        chk("post_rst_no_we", fcnt, fc);
        chk("post_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        ftm_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_feeder.md
Name: conv_feeder

Overview:
- Transmit side of the conv-unit load interface.
- Accepts one layer command, delivers the weight/feature configuration words on the two cfg channels, then streams weight and feature-map data onto the shared `di` bus.
- Drives `wb_we`/`fb_we` in unit-sized bursts, gated by the target unit's `wb_full`/`fb_full` back-pressure.
- Sits between the DDR read DMA (two source streams) and one conv unit.

Parameters:
- DATA_WIDTH, 64, width of data words and of `di`.
- UNIT_BURSTS_WEI, 32, words per weight unit; power of 2.
- UNIT_BURSTS_FTM, 1024, words per feature-map unit; power of 2.
- B_UNITS, 16, width of the per-command unit counts.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_cfg  in  64  [31:0] wcfg word, [63:32] fcfg word
- cmd_n_wei  in  B_UNITS  number of weight units to send
- cmd_n_ftm  in  B_UNITS  number of feature-map units to send
- cmd_clr  in  1  pulse buffer clears before sending
- cmd_valid  in  1  command valid
- cmd_ready  out  1  high in IDLE only
- wei_data  in  DATA_WIDTH  weight source word
- wei_valid  in  1  weight source valid
- wei_ready  out  1  weight source ready
- ftm_data  in  DATA_WIDTH  feature source word
- ftm_valid  in  1  feature source valid
- ftm_ready  out  1  feature source ready
- cfg_o_data  out  64  cfg word to conv unit
- cfg_o_valid  out  2  per-channel valid ([0] write side, [1] read side)
- cfg_o_ready  in  2  per-channel ready from conv unit
- wb_we  out  1  weight buffer write enable
- fb_we  out  1  feature buffer write enable
- wb_clr  out  1  weight buffer clear pulse
- fb_clr  out  1  feature buffer clear pulse
- di  out  DATA_WIDTH  write data
- wb_full  in  1  weight buffer cannot take a unit
- fb_full  in  1  feature buffer cannot take a unit
- done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset:
  - Asynchronous, active-high. Every register clears immediately and state goes to IDLE.
  - All outputs reset to 0, except `cmd_ready`, which is 1 in IDLE.
  - Reset mid-burst abandons the burst; no further `we` until a new command is accepted.
- States: IDLE, CFG, ARB, WEI, FTM, DONE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`: latch `cmd_cfg`, `cmd_n_wei`, `cmd_n_ftm`; clear `cfg_sent[1:0]`; go to CFG.
  - If `cmd_clr`, pulse `wb_clr` and `fb_clr` for exactly the next cycle.
- CFG:
  - `cfg_o_data` = latched cfg; `cfg_o_valid[k]` = ~`cfg_sent[k]`.
  - Channel k completes on the cycle `cfg_o_valid[k]` & `cfg_o_ready[k]`, which sets `cfg_sent[k]`. Channels complete independently and may complete in the same cycle.
  - When both are sent, go to ARB. Earliest: 1 cycle in CFG.
- ARB (unit boundary; evaluated once per cycle):
  - Weight priority: if `wei_rem`>0 and !`wb_full`, go to WEI.
  - Else if `ftm_rem`>0 and !`fb_full`, go to FTM.
  - Else if both remainders are 0, go to DONE.
  - Else stay in ARB.
  - `wb_full`/`fb_full` are sampled only in ARB; full rising during a unit does not stall it.
- WEI:
  - `wei_ready`=1; `ftm_ready`=0.
  - Each `wei_valid`&`wei_ready` cycle registers `di`<=`wei_data` and `wb_we`<=1 on the next cycle (latency 1). Otherwise `wb_we`<=0.
  - The word counter counts 0..UNIT_BURSTS_WEI-1.
  - On the last word: decrement `wei_rem`, go to ARB. `wei_ready` is 0 in ARB.
  - Source bubbles are tolerated; `we` stays low during them.
- FTM: identical to WEI, using the ftm source, `fb_we`, UNIT_BURSTS_FTM and `ftm_rem`.
- Mutual exclusion: `wb_we` and `fb_we` are never high in the same cycle; `di` is held when no `we` is asserted.
- DONE: `done`=1 for one cycle, then IDLE. A new command can be accepted the cycle after DONE.
- Zero counts: `cmd_n_wei`=`cmd_n_ftm`=0 runs CFG, then ARB, then DONE.
- Widths:
  - Word counter width is $clog2(UNIT_BURSTS_FTM).
  - Remainders are B_UNITS bits and never underflow.

Decomposition:
- Shared package holds:
  - the state encoding localparams;
  - the cfg field offsets (wcfg [31:0], fcfg [63:32]);
  - the DATA_WIDTH default.
- One natural sub-module: `conv_feeder_burst`. It is the word counter plus the source-to-`di`/`we` register stage, instantiated once per stream and parameterised by unit length.

Test Plan:
- Cfg handshake: `cmd_n_wei`=0, `cmd_n_ftm`=0; `cfg_o_ready`=01 for 3 cycles, then 10 -> `cfg_o_valid` 11→10→00; `done` pulses 1 cycle after ARB; zero `we`.
- Weight burst: `cmd_n_wei`=2, UNIT_BURSTS_WEI=32, `wei_valid` always 1 -> exactly 64 `wb_we` cycles; `di` equals the source words in order, delayed by 1 cycle; `fb_we` never asserted.
- Back-pressure: `wb_full`=1 while `cmd_n_wei`=1 and `cmd_n_ftm`=1 -> FTM unit (1024 `fb_we`) is sent first; weight unit starts only after `wb_full` drops.
- Bubbles: `wei_valid` toggling 1010… over a 32-word unit -> 32 `wb_we` pulses across 63 cycles; no extra or missing words.
- Clear and async reset: `cmd_clr`=1 -> `wb_clr`/`fb_clr` high exactly 1 cycle. `rst` asserted mid-FTM unit -> `fb_we`=0 immediately, `cmd_ready`=1 after release.
